calc_cmd_sequencer: RTL
=======================

// Module: calc_cmd_sequencer
// PURPOSE
//  Sequential front/back end for the combinational calculator. Accepts {A,B,op} commands over a
//  valid/ready handshake and drives the calculator operand ports from registers. Waits a fixed
//  settle time, then captures result + divide_by_zero with a tag into a small response FIFO.
//  Drains the FIFO over a second valid/ready handshake. Sits between the command source and the
//  calculator; the calculator is instantiated alongside it, not inside.
// PARAMETERS
//  A_W            4   operand width (A, B)
//  RES_W          8   result width (2*A_W)
//  DEPTH          4   response FIFO entries (power of 2, >=2)
//  SETTLE_CYCLES  1   clock edges from accept to capture (>=1)
//  TAG_W          4   sequence tag width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      one clock; reset is asynchronous and active-low
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when cmd_valid&&cmd_ready at clk edge
//  cmd_a        in   A_W    operand A
//  cmd_b        in   A_W    operand B
//  cmd_op       in   2      00 add, 01 sub, 10 mul, 11 div
//  calc_a       out  A_W    registered A to calculator
//  calc_b       out  A_W    registered B to calculator
//  calc_op      out  2      registered op to calculator
//  calc_result  in   RES_W  calculator result
//  calc_dbz     in   1      calculator divide_by_zero
//  rsp_valid    out  1      FIFO not empty
//  rsp_ready    in   1      consumer pops when rsp_valid&&rsp_ready
//  rsp_result   out  RES_W  head entry result
//  rsp_dbz      out  1      head entry divide-by-zero flag
//  rsp_op       out  2      head entry op
//  rsp_tag      out  TAG_W  head entry tag
//  dbz_count    out  8      saturating count of captured dbz=1 responses
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; calc_a/b/op=0; FIFO empty (rsp_valid=0, rsp_* = 0);
//   tag=0; dbz_count=0; cmd_ready=0 while rst_n=0. Any in-flight command is dropped.
//  FSM IDLE -> WAIT -> IDLE:
//   IDLE: cmd_ready = (fifo_count < DEPTH). On accept: load calc_a/b/op from cmd_*, latch cur_tag=tag,
//    tag <= tag+1 (wraps 2^TAG_W-1 -> 0), cnt <= SETTLE_CYCLES-1, go WAIT.
//   WAIT: cmd_ready=0. If cnt!=0: cnt--. If cnt==0: at this edge push {calc_result, calc_dbz,
//    calc_op, cur_tag} into FIFO, go IDLE.
//  Latency: accept at edge t0 -> capture at edge t0+SETTLE_CYCLES; rsp_valid high after that edge
//   if FIFO was empty. Back-to-back throughput = 1 cmd per SETTLE_CYCLES+1 cycles.
//  calc_a/b/op hold last command after capture (no return to 0).
//  Only one command in flight; accept requires a free slot, so capture never meets a full FIFO.
//   A pop during WAIT only frees space.
//  FIFO: push and pop in same cycle -> count unchanged, head advances. Pop when empty ignored.
//   rsp_* reflect head entry combinationally from storage; undefined content is forced to 0 when empty.
//  dbz_count: +1 on each capture with calc_dbz=1; saturates at 255.
//  rsp_result captured verbatim for dbz=1 (value not checked).
// STRUCTURE
//  calc_pkg: OP_ADD/OP_SUB/OP_MUL/OP_DIV localparams, state encoding (ST_IDLE, ST_WAIT).
//  Sub-module calc_rsp_fifo (DEPTH x {RES_W+1+2+TAG_W}, rd/wr pointers with extra wrap bit,
//   count output). FSM, tag counter and dbz_count stay in calc_cmd_sequencer.
// TESTING (bench instantiates calculator on calc_* ports, defaults, rsp_ready=1 unless stated)
//  1 A=3,B=2,op=00 -> rsp_result=8'h05, dbz=0, tag=0. Then 5,3,01 -> 8'h02, tag=1.
//    Then 2,4,10 -> 8'h08. Then 8,2,11 -> 8'h04. Each arrives 1 edge after accept.
//  2 A=8,B=0,op=11 -> rsp_dbz=1, rsp_op=11, dbz_count=1.
//  3 rsp_ready=0, issue 4 cmds -> cmd_ready=0 after 4th capture, rsp_valid=1, head tag=0.
//    One pop -> cmd_ready=1 next cycle. Drain yields tags 0..3 in order.
//  4 Issue 17 cmds -> tags run 0..15 then 0 (wrap).
//  5 Assert rst_n=0 mid-WAIT -> rsp_valid=0, calc_*=0 immediately, no response for dropped cmd.
//    First cmd after reset carries tag=0.
//  6 SETTLE_CYCLES=3 build: cmd_valid held high -> accepts every 4th cycle, capture 3 edges after
//    each accept. 300 dbz cmds -> dbz_count=255.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcode values and sequencer state encoding for the calculator front/back end
package calc_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
endpackage

// File: rtl/calc_rsp_fifo.sv
// calc_rsp_fifo: response queue with wrap-bit pointers; head is zeroed while empty
module calc_rsp_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_pop;
    assign o_count = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: registers calculator operands, waits a settle time, then queues the
// tagged result for a downstream consumer
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int A_W           = 4,
    parameter int RES_W         = 8,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [A_W-1:0]   i_cmd_a,
    input  logic [A_W-1:0]   i_cmd_b,
    input  logic [1:0]       i_cmd_op,
    output logic [A_W-1:0]   o_calc_a,
    output logic [A_W-1:0]   o_calc_b,
    output logic [1:0]       o_calc_op,
    input  logic [RES_W-1:0] i_calc_result,
    input  logic             i_calc_dbz,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [RES_W-1:0] o_rsp_result,
    output logic             o_rsp_dbz,
    output logic [1:0]       o_rsp_op,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic [7:0]       o_dbz_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int EW = RES_W + 1 + 2 + TAG_W;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [A_W-1:0]   r_calc_a;
    logic [A_W-1:0]   r_calc_b;
    logic [1:0]       r_calc_op;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_cur_tag;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_dbz_count;
    logic             w_accept;
    logic             w_capture;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic [EW-1:0]    w_head;
    assign o_calc_a    = r_calc_a;
    assign o_calc_b    = r_calc_b;
    assign o_calc_op   = r_calc_op;
    assign o_dbz_count = r_dbz_count;
    assign o_rsp_valid = !w_empty;
    assign {o_rsp_result, o_rsp_dbz, o_rsp_op, o_rsp_tag} = w_head;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end
    // a free slot is required at accept, so the capture can never overflow the FIFO
    always_comb begin
        w_state_nxt = r_state;
        o_cmd_ready = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        if (r_state == ST_IDLE) begin
            o_cmd_ready = i_rst_n && (w_count < (AW+1)'(DEPTH));
            w_accept    = i_cmd_valid && o_cmd_ready;
            w_state_nxt = w_accept ? ST_WAIT : ST_IDLE;
        end else if (r_cnt == '0) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_IDLE;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_calc_a    <= '0;
            r_calc_b    <= '0;
            r_calc_op   <= '0;
            r_tag       <= '0;
            r_cur_tag   <= '0;
            r_cnt       <= '0;
            r_dbz_count <= '0;
        end else begin
            if (w_accept) begin
                r_calc_a  <= i_cmd_a;
                r_calc_b  <= i_cmd_b;
                r_calc_op <= i_cmd_op;
                r_cur_tag <= r_tag;
                r_tag     <= r_tag + 1'b1;
                r_cnt     <= CW'(SETTLE_CYCLES - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture && i_calc_dbz && r_dbz_count != 8'hFF)
                r_dbz_count <= r_dbz_count + 1'b1;
        end
    end
    calc_rsp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_capture),
        .i_pop   (i_rsp_ready),
        .i_data  ({i_calc_result, i_calc_dbz, r_calc_op, r_cur_tag}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );
endmodule
